// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: two-port round-robin front end for a shared AES-128 core.
// Sequences launch, completion/timeout, tagged response and core clear.
module aes_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         REQ0_VALID,
  output logic         REQ0_READY,
  input  logic [127:0] REQ0_DATA,
  input  logic [127:0] REQ0_KEY,
  input  logic         REQ1_VALID,
  output logic         REQ1_READY,
  input  logic [127:0] REQ1_DATA,
  input  logic [127:0] REQ1_KEY,
  output logic         RSP_VALID,
  input  logic         RSP_READY,
  output logic         RSP_ID,
  output logic [127:0] RSP_DATA,
  output logic         RSP_ERR,
  output logic         CORE_ED,
  output logic         CORE_DAVAILABLE,
  output logic [127:0] CORE_IN,
  output logic [127:0] CORE_KEY,
  output logic         CORE_RESET,
  input  logic [127:0] CORE_OUT,
  input  logic         CORE_DONE
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_RESP,
    S_CLEAR
  } state_t;

  state_t          state;
  logic            last_grant;
  logic            owner;
  logic [127:0]    job_data;
  logic [127:0]    job_key;
  logic [CW-1:0]   cnt;
  logic            rsp_valid;
  logic [127:0]    rsp_data;
  logic            rsp_err;
  logic            core_ed;
  logic            core_dav;
  logic            win;
  logic            idle_ok;

  // Winner select: lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (REQ0_VALID & REQ1_VALID):  win = ~last_grant;
      (REQ1_VALID & ~REQ0_VALID): win = 1'b1;
      default:                    win = 1'b0;
    endcase
  end

  assign idle_ok    = (state == S_IDLE) & ~RESET;
  assign REQ0_READY = idle_ok & REQ0_VALID & ~win;
  assign REQ1_READY = idle_ok & REQ1_VALID & win;

  assign RSP_VALID       = rsp_valid;
  assign RSP_ID          = owner;
  assign RSP_DATA        = rsp_data;
  assign RSP_ERR         = rsp_err;
  assign CORE_ED         = core_ed;
  assign CORE_DAVAILABLE = core_dav;
  assign CORE_IN         = job_data;
  assign CORE_KEY        = job_key;
  assign CORE_RESET      = RESET | (state == S_CLEAR);

  // Job sequencer with registered core and response outputs.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      job_data   <= '0;
      job_key    <= '0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      core_ed    <= 1'b0;
      core_dav   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (REQ0_VALID | REQ1_VALID) begin
            job_data   <= win ? REQ1_DATA : REQ0_DATA;
            job_key    <= win ? REQ1_KEY : REQ0_KEY;
            owner      <= win;
            last_grant <= win;
            core_ed    <= 1'b1;
            core_dav   <= 1'b1;
            state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cnt      <= '0;
          core_dav <= 1'b0;
          state    <= S_BUSY;
        end
        S_BUSY: begin
          cnt <= cnt + CW'(1);
          if (CORE_DONE) begin
            rsp_data  <= CORE_OUT;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            core_ed   <= 1'b0;
            state     <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            core_ed   <= 1'b0;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (RSP_READY) begin
            rsp_valid <= 1'b0;
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb_aes_req_arbiter: scoreboard bench with a behavioural AES-128 core
// and a reference AES model computed from the cipher definition.
module tb_aes_req_arbiter;

  localparam int TO = 16;

  logic         CLOCK = 1'b0;
  logic         RESET;
  logic         REQ0_VALID, REQ0_READY;
  logic [127:0] REQ0_DATA, REQ0_KEY;
  logic         REQ1_VALID, REQ1_READY;
  logic [127:0] REQ1_DATA, REQ1_KEY;
  logic         RSP_VALID, RSP_READY, RSP_ID, RSP_ERR;
  logic [127:0] RSP_DATA;
  logic         CORE_ED, CORE_DAVAILABLE, CORE_RESET, CORE_DONE;
  logic [127:0] CORE_IN, CORE_KEY, CORE_OUT;

  always #5 CLOCK = ~CLOCK;

  aes_req_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY),
    .REQ0_DATA(REQ0_DATA), .REQ0_KEY(REQ0_KEY),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY),
    .REQ1_DATA(REQ1_DATA), .REQ1_KEY(REQ1_KEY),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .CORE_ED(CORE_ED), .CORE_DAVAILABLE(CORE_DAVAILABLE),
    .CORE_IN(CORE_IN), .CORE_KEY(CORE_KEY),
    .CORE_RESET(CORE_RESET), .CORE_OUT(CORE_OUT),
    .CORE_DONE(CORE_DONE)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  initial begin
    logic [7:0] p, v8;
    for (int v = 0; v < 256; v++) begin
      v8 = v[7:0];
      p = 8'h00;
      if (v != 0) begin
        p = 8'h01;
        for (int j = 0; j < 254; j++) p = gm(p, v8);
      end
      sbox[v] = p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]}
              ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
    end
  end

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key,
                                           input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] st, ns;
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    st = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) b[i] = sbox[st[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          t[4*c+q] = b[4*((c+q)%4)+q];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gm(a0, 8'd2) ^ gm(a1, 8'd3) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gm(a1, 8'd2) ^ gm(a2, 8'd3) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'd2) ^ gm(a3, 8'd3);
          t[4*c+3] = gm(a0, 8'd3) ^ a1 ^ a2 ^ gm(a3, 8'd2);
        end
      end
      for (int i = 0; i < 16; i++) ns[127-8*i -: 8] = t[i];
      st = ns ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return st;
  endfunction

  function automatic logic [127:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- 10-round core model ----------------
  bit           core_hang = 1'b0;
  logic         run;
  int           rounds;
  logic [127:0] pend;

  always @(posedge CLOCK) begin
    cyc++;
    if (CORE_RESET) begin
      CORE_DONE <= 1'b0;
      CORE_OUT  <= '0;
      run       <= 1'b0;
    end else if (CORE_ED && CORE_DAVAILABLE) begin
      run    <= 1'b1;
      rounds <= 0;
      pend   <= aes_enc(CORE_KEY, CORE_IN);
    end else if (run && CORE_ED) begin
      rounds <= rounds + 1;
      if (rounds == 9) begin
        run <= 1'b0;
        if (!core_hang) begin
          CORE_DONE <= 1'b1;
          CORE_OUT  <= pend;
        end
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic         id;
    logic [127:0] data;
    logic         err;
    int           acc;
  } exp_t;

  exp_t         exp_q[$];
  int           grants[$];
  logic         m_last = 1'b1;
  bit           rr_phase = 1'b0;
  int           prev_acc = -1;
  bit           prev_v = 1'b0;
  int           dav_len = 0;
  bit           clr_pend = 1'b0;
  bit           idle_chk = 1'b0;
  logic [127:0] snap_d, last_d;
  logic         snap_id, snap_err, last_id, last_err;

  always @(negedge CLOCK) begin
    if (RESET) begin
      chk("core_reset_in_reset", CORE_RESET, 1);
      exp_q.delete();
      m_last = 1'b1;
      prev_v = 1'b0;
      dav_len = 0;
      clr_pend = 1'b0;
      idle_chk = 1'b0;
      prev_acc = -1;
    end else begin
      if (idle_chk) begin
        chk("done_cleared", CORE_DONE, 0);
        idle_chk = 1'b0;
      end
      if (clr_pend) begin
        chk("clear_pulse", CORE_RESET, 1);
        clr_pend = 1'b0;
        idle_chk = 1'b1;
      end
      if (CORE_DAVAILABLE) dav_len++;
      else if (dav_len != 0) begin
        chk("dav_len", dav_len, 1);
        dav_len = 0;
      end
      if ((REQ0_VALID && REQ0_READY) || (REQ1_VALID && REQ1_READY)) begin
        exp_t e;
        logic want;
        chk("one_grant", REQ0_READY & REQ1_READY, 0);
        want = (REQ0_VALID && REQ1_VALID) ? ~m_last : REQ1_VALID;
        chk("grant", REQ1_READY, want);
        m_last = want;
        e.id  = want;
        e.err = core_hang;
        e.data = core_hang ? 128'h0 :
                 (want ? aes_enc(REQ1_KEY, REQ1_DATA)
                       : aes_enc(REQ0_KEY, REQ0_DATA));
        e.acc = cyc + 1;
        if (rr_phase && prev_acc >= 0)
          chk("rr_period", e.acc - prev_acc, 15);
        prev_acc = e.acc;
        grants.push_back(int'(REQ1_READY));
        exp_q.push_back(e);
      end
      if (RSP_VALID) begin
        chk("no_ready_in_resp", REQ0_READY | REQ1_READY, 0);
        if (!prev_v) begin
          snap_d = RSP_DATA;
          snap_id = RSP_ID;
          snap_err = RSP_ERR;
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_rsp: got id %0d data %h expected none",
                     RSP_ID, RSP_DATA);
          end else begin
            chk("latency", cyc - exp_q[0].acc, exp_q[0].err ? TO + 1 : 12);
          end
        end else begin
          chk("hold_data", RSP_DATA, snap_d);
          chk("hold_id", RSP_ID, snap_id);
          chk("hold_err", RSP_ERR, snap_err);
        end
        if (RSP_READY && exp_q.size() > 0) begin
          exp_t e2;
          e2 = exp_q.pop_front();
          chk("rsp_id", RSP_ID, e2.id);
          chk("rsp_data", RSP_DATA, e2.data);
          chk("rsp_err", RSP_ERR, e2.err);
          last_d = RSP_DATA;
          last_id = RSP_ID;
          last_err = RSP_ERR;
          clr_pend = 1'b1;
        end
      end
      prev_v = RSP_VALID;
    end
  end

  // ---------------- response consumer ----------------
  int rmode = 0;
  int bp_cnt = 0;

  initial begin
    RSP_READY = 1'b1;
    forever begin
      @(posedge CLOCK);
      #1;
      case (rmode)
        0: RSP_READY = 1'b1;
        1: RSP_READY = 1'($urandom_range(0, 1));
        default: begin
          if (RSP_VALID) begin
            RSP_READY = (bp_cnt >= 20);
            bp_cnt++;
          end else begin
            bp_cnt = 0;
            RSP_READY = 1'b0;
          end
        end
      endcase
    end
  end

  // ---------------- requester driver ----------------
  task automatic send(input bit id, input logic [127:0] d,
                      input logic [127:0] k);
    int n;
    logic rdy;
    n = 0;
    if (id) begin
      REQ1_VALID = 1'b1; REQ1_DATA = d; REQ1_KEY = k;
    end else begin
      REQ0_VALID = 1'b1; REQ0_DATA = d; REQ0_KEY = k;
    end
    do begin
      @(negedge CLOCK);
      n++;
      rdy = id ? REQ1_READY : REQ0_READY;
    end while (!rdy && n < 400);
    if (!rdy) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: req%0d got no READY in %0d cycles expected acceptance",
               id, n);
    end
    @(posedge CLOCK);
    #1;
    if (id) REQ1_VALID = 1'b0;
    else REQ0_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || RSP_VALID) && n < 2000) begin
      @(posedge CLOCK);
      n++;
    end
    if (n >= 2000) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (3) @(posedge CLOCK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    RESET = 1'b1;
    REQ0_VALID = 1'b0; REQ0_DATA = '0; REQ0_KEY = '0;
    REQ1_VALID = 1'b0; REQ1_DATA = '0; REQ1_KEY = '0;
    repeat (3) @(posedge CLOCK);
    #1;
    REQ0_VALID = 1'b1;
    REQ1_VALID = 1'b1;
    #1;
    chk("rst_req0_ready", REQ0_READY, 0);
    chk("rst_req1_ready", REQ1_READY, 0);
    chk("rst_rsp_valid", RSP_VALID, 0);
    chk("rst_rsp_data", RSP_DATA, 0);
    chk("rst_rsp_err", RSP_ERR, 0);
    chk("rst_rsp_id", RSP_ID, 0);
    chk("rst_core_ed", CORE_ED, 0);
    chk("rst_core_dav", CORE_DAVAILABLE, 0);
    chk("rst_core_in", CORE_IN, 0);
    chk("rst_core_key", CORE_KEY, 0);
    chk("rst_core_reset", CORE_RESET, 1);
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;

    // both requesters continuously valid
    grants.delete();
    rr_phase = 1'b1;
    fork
      begin
        for (int j = 0; j < 2; j++) send(1'b0, rnd(), rnd());
      end
      begin
        for (int j = 0; j < 2; j++) send(1'b1, rnd(), rnd());
      end
    join
    drain();
    rr_phase = 1'b0;
    chk("rr_count", grants.size(), 4);
    for (int j = 0; j < 4; j++)
      if (j < grants.size()) chk("rr_order", grants[j], j % 2);

    // known-answer job
    send(1'b0, 128'h00112233445566778899aabbccddeeff,
         128'h000102030405060708090a0b0c0d0e0f);
    drain();
    chk("kat_data", last_d, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("kat_id", last_id, 0);
    chk("kat_err", last_err, 0);

    // backpressure with a waiting second requester
    rmode = 2;
    fork
      send(1'b0, rnd(), rnd());
      begin
        repeat (3) @(posedge CLOCK);
        #1;
        send(1'b1, rnd(), rnd());
      end
    join
    drain();
    rmode = 0;

    // core never completes
    core_hang = 1'b1;
    send(1'b1, rnd(), rnd());
    drain();
    core_hang = 1'b0;
    chk("to_err", last_err, 1);
    chk("to_data", last_d, 0);

    // reset while the core is busy
    send(1'b0, rnd(), rnd());
    repeat (4) @(posedge CLOCK);
    #1;
    RESET = 1'b1;
    #2;
    chk("mid_core_reset", CORE_RESET, 1);
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    chk("mid_rsp_valid", RSP_VALID, 0);
    repeat (20) @(posedge CLOCK);
    #1;
    chk("mid_no_rsp", RSP_VALID, 0);
    send(1'b1, 128'h00112233445566778899aabbccddeeff,
         128'h000102030405060708090a0b0c0d0e0f);
    drain();
    chk("mid_next_id", last_id, 1);
    chk("mid_next_data", last_d, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // random traffic with random consumer stalls
    rmode = 1;
    fork
      begin
        for (int j = 0; j < 5; j++) begin
          repeat ($urandom_range(0, 20)) @(posedge CLOCK);
          #1;
          send(1'b0, rnd(), rnd());
        end
      end
      begin
        for (int j = 0; j < 5; j++) begin
          repeat ($urandom_range(0, 20)) @(posedge CLOCK);
          #1;
          send(1'b1, rnd(), rnd());
        end
      end
    join
    drain();
    rmode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
